// File: rtl/ksa.sv
// -----------------------------------------------------------------------------
// ksa -- RC4 key-scheduling engine.
//
// Walks a 256-byte S array held in an external synchronous-read memory that
// has already been filled by the init stage.
//   j = 0
//   for i = 0..255:
//     j = j + S[i] + key_byte[i mod 3]   (8-bit, wrapping)
//     swap S[i], S[j]
// Each iteration takes six cycles: RDI, CALC, RDJ, LATJ, WRI, WRJ.
//
// Ports
//   clk     : single clock, all state updates on its rising edge
//   rst_n   : asynchronous active-low reset, returns the engine to IDLE
//   en      : start request, sampled only while rdy = 1
//   rdy     : 1 while idle and able to accept en
//   key     : KEY_W-bit cipher key, latched on the accept edge
//   addr    : S-array memory address
//   rddata  : memory read data, valid the cycle after addr is presented
//   wrdata  : memory write data
//   wren    : memory write enable (write wrdata to addr at this clock edge)
//
// Only KEY_W = 24 is supported: the key is three bytes, most significant byte
// used first.
// -----------------------------------------------------------------------------
module ksa #(
  parameter int KEY_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  output logic [7:0]       addr,
  input  logic [7:0]       rddata,
  output logic [7:0]       wrdata,
  output logic             wren
);

  typedef enum logic [2:0] {
    IDLE,
    RDI,
    CALC,
    RDJ,
    LATJ,
    WRI,
    WRJ
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       i_q, i_d;
  logic [7:0]       j_q, j_d;
  logic [1:0]       kidx_q, kidx_d;   // i mod 3, stepped alongside i
  logic [KEY_W-1:0] key_q, key_d;
  logic [7:0]       si_q, si_d;
  logic [7:0]       sj_q, sj_d;
  logic [7:0]       key_byte;

  // Tracking i mod 3 with its own small counter avoids a divider on i.
  always_comb begin
    unique case (kidx_q)
      2'd0:    key_byte = key_q[KEY_W-1 -: 8];
      2'd1:    key_byte = key_q[KEY_W-9 -: 8];
      default: key_byte = key_q[7:0];
    endcase
  end

  // Next-state and register updates.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    si_d    = si_q;
    sj_d    = sj_q;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          key_d   = key;
          i_d     = 8'd0;
          j_d     = 8'd0;
          kidx_d  = 2'd0;
          state_d = RDI;
        end
      end
      RDI:  state_d = CALC;
      CALC: begin
        si_d    = rddata;
        // 8-bit operands and result: the carry is dropped, wrapping mod 256.
        j_d     = j_q + rddata + key_byte;
        state_d = RDJ;
      end
      RDJ:  state_d = LATJ;
      LATJ: begin
        sj_d    = rddata;
        state_d = WRI;
      end
      WRI:  state_d = WRJ;
      WRJ: begin
        if (i_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
          state_d = RDI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      kidx_q  <= 2'd0;
      key_q   <= '0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  // Moore outputs: functions of state and registers only. When i = j the two
  // writes both land on the same address and the second stores si, so S is
  // left unchanged.
  always_comb begin
    rdy    = 1'b0;
    wren   = 1'b0;
    addr   = 8'd0;
    wrdata = 8'd0;
    unique case (state_q)
      IDLE: rdy  = 1'b1;
      RDI:  addr = i_q;
      RDJ:  addr = j_q;
      WRI: begin
        addr   = i_q;
        wrdata = sj_q;
        wren   = 1'b1;
      end
      WRJ: begin
        addr   = j_q;
        wrdata = si_q;
        wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// -----------------------------------------------------------------------------
// tb_ksa -- self-checking bench for ksa.
// A synchronous-read 256-byte memory model sits on the DUT memory port. Every
// run is predicted by a plain software RC4 key schedule that yields the full
// list of expected (addr, data) writes and the final S array.
// -----------------------------------------------------------------------------
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] key = 24'd0;
  logic        rdy;
  logic        wren;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;

  ksa #(.KEY_W(24)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  always #5 clk = ~clk;

  // Memory model and preload image.
  logic [7:0] mem    [256];
  logic [7:0] init_s [256];
  logic       mem_load = 1'b0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_s[k];
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  // Reference results and captured write log.
  logic [7:0] exp_a [512];
  logic [7:0] exp_d [512];
  logic [7:0] exp_s [256];
  logic [7:0] log_a [1024];
  logic [7:0] log_d [1024];
  int log_n, busy_n, wren_n;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Software RC4 key schedule starting from init_s.
  task automatic model_ksa(input logic [23:0] k);
    int         j;
    logic [7:0] s  [256];
    logic [7:0] kb [3];
    logic [7:0] t;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int n = 0; n < 256; n++) s[n] = init_s[n];
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(s[i]) + int'(kb[i % 3])) % 256;
      exp_a[2*i]   = 8'(i);
      exp_d[2*i]   = s[j];
      exp_a[2*i+1] = 8'(j);
      exp_d[2*i+1] = s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int n = 0; n < 256; n++) exp_s[n] = s[n];
  endtask

  task automatic set_identity();
    for (int n = 0; n < 256; n++) init_s[n] = 8'(n);
  endtask

  task automatic set_shuffled();
    logic [7:0] t;
    int         r;
    set_identity();
    for (int n = 255; n > 0; n--) begin
      r = int'($urandom_range(n, 0));
      t = init_s[n]; init_s[n] = init_s[r]; init_s[r] = t;
    end
  endtask

  task automatic load_mem();
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (rdy !== 1'b1 && t < 3000) begin
      tick();
      t++;
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s idle_timeout rdy=%b expected 1", tag, rdy);
    end
  endtask

  task automatic start_run(input logic [23:0] k, input bit hold);
    key = k;
    en  = 1'b1;
    tick();
    if (!hold) en = 1'b0;
  endtask

  // Clock through a busy period, logging writes. Stops early at busy cycle
  // stop_at (if nonzero); pulses en with poke_key at busy cycle poke_at.
  task automatic collect(input int stop_at, input int poke_at,
                         input logic [23:0] poke_key);
    log_n  = 0;
    busy_n = 0;
    wren_n = 0;
    while (rdy === 1'b0 && busy_n < 2000) begin
      if (wren === 1'b1) begin
        if (log_n < 1024) begin
          log_a[log_n] = addr;
          log_d[log_n] = wrdata;
        end
        log_n++;
        wren_n++;
      end
      busy_n++;
      if (stop_at != 0 && busy_n == stop_at) return;
      if (poke_at > 0 && busy_n == poke_at) begin
        en  = 1'b1;
        key = poke_key;
      end else if (poke_at > 0 && busy_n == poke_at + 1) begin
        en = 1'b0;
      end
      tick();
    end
  endtask

  function automatic int first_write_bad();
    if (log_n != 512) return -2;
    for (int k = 0; k < 512; k++)
      if (log_a[k] !== exp_a[k] || log_d[k] !== exp_d[k]) return k;
    return -1;
  endfunction

  function automatic int first_mem_bad();
    for (int k = 0; k < 256; k++)
      if (mem[k] !== exp_s[k]) return k;
    return -1;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1;
    n_cmp++; if (rdy !== 1'b1)     begin n_bad++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    n_cmp++; if (wren !== 1'b0)    begin n_bad++; $display("FAIL reset_wren got=%b exp=0", wren); end
    n_cmp++; if (addr !== 8'd0)    begin n_bad++; $display("FAIL reset_addr got=%h exp=00", addr); end
    n_cmp++; if (wrdata !== 8'd0)  begin n_bad++; $display("FAIL reset_wrdata got=%h exp=00", wrdata); end
    en = 1'b1;
    tick();
    tick();
    n_cmp++; if (rdy !== 1'b1)     begin n_bad++; $display("FAIL reset_hold_rdy got=%b exp=1", rdy); end
    en = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (rdy !== 1'b1)     begin n_bad++; $display("FAIL reset_release_rdy got=%b exp=1", rdy); end
  endtask

  task automatic test_zero_key();
    logic [7:0] ref_a [8];
    logic [7:0] ref_d [8];
    int bad;
    ref_a = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd5};
    ref_d = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2, 8'd5, 8'd2};
    set_identity();
    load_mem();
    model_ksa(24'h000000);
    wait_idle("zero_key");
    start_run(24'h000000, 1'b0);
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL zero_key_accept rdy=%b exp=0", rdy); end
    collect(0, 0, 24'd0);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (log_a[k] !== ref_a[k] || log_d[k] !== ref_d[k]) begin
        n_bad++;
        $display("FAIL zero_key_write%0d got %h<=%h exp %h<=%h", k, log_a[k], log_d[k], ref_a[k], ref_d[k]);
      end
    end
    bad = first_write_bad();
    n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL zero_key_all_writes first_bad=%0d log_n=%0d exp first_bad=-1", bad, log_n); end
  endtask

  task automatic test_key_order();
    set_identity();
    load_mem();
    wait_idle("key_order");
    start_run(24'h010203, 1'b0);
    collect(0, 0, 24'd0);
    n_cmp++; if (log_a[0] !== 8'd0 || log_d[0] !== 8'd1) begin n_bad++; $display("FAIL key_order_w0 got %h<=%h exp 00<=01", log_a[0], log_d[0]); end
    n_cmp++; if (log_a[1] !== 8'd1 || log_d[1] !== 8'd0) begin n_bad++; $display("FAIL key_order_w1 got %h<=%h exp 01<=00", log_a[1], log_d[1]); end
  endtask

  task automatic test_timing();
    logic [23:0] k;
    int bad;
    k = 24'($urandom);
    set_identity();
    load_mem();
    model_ksa(k);
    wait_idle("timing");
    start_run(k, 1'b0);
    collect(0, 0, 24'd0);
    n_cmp++; if (busy_n != 1536) begin n_bad++; $display("FAIL timing_busy got=%0d exp=1536", busy_n); end
    n_cmp++; if (rdy !== 1'b1)   begin n_bad++; $display("FAIL timing_rdy_after got=%b exp=1", rdy); end
    n_cmp++; if (wren_n != 512)  begin n_bad++; $display("FAIL timing_wren_cycles got=%0d exp=512", wren_n); end
    bad = first_write_bad();
    n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL timing_writes key=%h first_bad=%0d exp=-1", k, bad); end
  endtask

  task automatic test_en_busy();
    logic [23:0] k;
    int bad;
    k = 24'($urandom);
    set_identity();
    load_mem();
    model_ksa(k);
    wait_idle("en_busy");
    start_run(k, 1'b0);
    collect(0, 100, ~k);
    n_cmp++; if (busy_n != 1536) begin n_bad++; $display("FAIL en_busy_length got=%0d exp=1536", busy_n); end
    bad = first_write_bad();
    n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL en_busy_writes first_bad=%0d exp=-1", bad); end
    tick();
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL en_busy_no_restart rdy=%b exp=1", rdy); end
  endtask

  task automatic test_reset_mid_run();
    logic [23:0] k;
    int bad;
    k = 24'($urandom);
    set_identity();
    load_mem();
    wait_idle("reset_mid");
    start_run(k, 1'b0);
    collect(700, 0, 24'd0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rdy !== 1'b1)  begin n_bad++; $display("FAIL reset_mid_rdy got=%b exp=1", rdy); end
    n_cmp++; if (wren !== 1'b0) begin n_bad++; $display("FAIL reset_mid_wren got=%b exp=0", wren); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (rdy !== 1'b1)  begin n_bad++; $display("FAIL reset_mid_idle_after got=%b exp=1", rdy); end
    // The aborted run leaves memory as it was; the fresh run starts from it.
    for (int n = 0; n < 256; n++) init_s[n] = mem[n];
    model_ksa(k);
    start_run(k, 1'b0);
    collect(0, 0, 24'd0);
    bad = first_write_bad();
    n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL reset_mid_fresh_writes first_bad=%0d exp=-1", bad); end
    bad = first_mem_bad();
    n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL reset_mid_fresh_mem first_bad=%0d exp=-1", bad); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] k;
    int bad;
    k = 24'($urandom);
    set_identity();
    load_mem();
    model_ksa(k);
    wait_idle("b2b");
    start_run(k, 1'b1);
    collect(0, 0, 24'd0);
    n_cmp++; if (busy_n != 1536) begin n_bad++; $display("FAIL b2b_first_length got=%0d exp=1536", busy_n); end
    bad = first_write_bad();
    n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL b2b_first_writes first_bad=%0d exp=-1", bad); end
    tick();
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_restart rdy=%b exp=0", rdy); end
    en = 1'b0;
    for (int n = 0; n < 256; n++) init_s[n] = exp_s[n];
    model_ksa(k);
    collect(0, 0, 24'd0);
    n_cmp++; if (busy_n != 1536) begin n_bad++; $display("FAIL b2b_second_length got=%0d exp=1536", busy_n); end
    bad = first_mem_bad();
    n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL b2b_second_mem first_bad=%0d exp=-1", bad); end
  endtask

  task automatic test_end_to_end();
    int bad;
    int cnt [256];
    int dup;
    set_identity();
    load_mem();
    model_ksa(24'h00033C);
    wait_idle("e2e");
    start_run(24'h00033C, 1'b0);
    collect(0, 0, 24'd0);
    bad = first_mem_bad();
    n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL e2e_mem first_bad=%0d exp=-1", bad); end
    for (int n = 0; n < 256; n++) cnt[n] = 0;
    for (int n = 0; n < 256; n++) cnt[mem[n]]++;
    dup = 0;
    for (int n = 0; n < 256; n++) if (cnt[n] != 1) dup++;
    n_cmp++; if (dup != 0) begin n_bad++; $display("FAIL e2e_permutation bad_values=%0d exp=0", dup); end
  endtask

  task automatic test_random();
    logic [23:0] k;
    int bad;
    for (int r = 0; r < 3; r++) begin
      k = 24'($urandom);
      set_shuffled();
      load_mem();
      model_ksa(k);
      wait_idle("random");
      start_run(k, 1'b0);
      collect(0, 0, 24'd0);
      bad = first_write_bad();
      n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL random%0d_writes key=%h first_bad=%0d exp=-1", r, k, bad); end
      bad = first_mem_bad();
      n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL random%0d_mem key=%h first_bad=%0d exp=-1", r, k, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_key_order();
    test_timing();
    test_en_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_end_to_end();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
